drm_axil_req_arbiter: RTL and testbench
=======================================

DRM_AXIL_REQ_ARBITER -- requirements
Module: drm_axil_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: AXI4-Lite address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit, range 2..65535.
REQ-003 SHALL have port s_axi_aclk, input, 1: single clock for all logic.
REQ-004 SHALL have port s_axi_arstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2: request strobe; bit i belongs to requester i.
REQ-006 SHALL have port req_we, input, 2: 1 = write, 0 = read, per requester.
REQ-007 SHALL have port req_addr, input, 2*ADDR_W: byte address; slice i belongs to requester i.
REQ-008 SHALL have port req_wdata, input, 64: write data; slice i belongs to requester i.
REQ-009 SHALL have port req_ready, output, 2: one-cycle accept pulse per requester.
REQ-010 SHALL have port rsp_valid, output, 2: one-cycle completion pulse per requester.
REQ-011 SHALL have port rsp_rdata, output, 32: read data; valid with rsp_valid.
REQ-012 SHALL have port rsp_err, output, 1: 1 = SLVERR, DECERR or timeout; valid with rsp_valid.
REQ-013 SHALL have AXI4-Lite master ports m_axi_awvalid/awready/awaddr[ADDR_W], wvalid/wready/wdata[32]/wstrb[4], bvalid/bready/bresp[2], arvalid/arready/araddr[ADDR_W] and rvalid/rready/rdata[32]/rresp[2], with standard directions, toward the DRM controller register slave.

Function
REQ-014 SHALL use FSM states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA and RESP, with one transaction outstanding at most.
REQ-015 In IDLE with any req_valid set, SHALL pulse req_ready for the granted requester for one cycle, register its we/addr/wdata, and go to WR_ADDR or RD_ADDR on the next edge.
REQ-016 SHALL use round-robin arbitration: when both requesters are valid, grant the one not granted last; after reset, requester 0 wins the first tie.
REQ-017 WR_ADDR SHALL assert awvalid and wvalid together in the cycle after acceptance; each valid drops independently on its own handshake; go to WR_RESP once both handshakes have occurred, including the same-cycle case.
REQ-018 wstrb SHALL be 4'hF; bready SHALL be 1 only in WR_RESP; the bvalid handshake goes to RESP.
REQ-019 RD_ADDR SHALL hold arvalid until arready, then go to RD_DATA.
REQ-020 RD_DATA SHALL hold rready at 1 until rvalid; on rvalid, capture rdata and rresp, then go to RESP.
REQ-021 RESP SHALL last one cycle: pulse rsp_valid for the granted requester only, with rsp_err = resp[1] and rsp_rdata = captured data (0 for writes), then return to IDLE.
REQ-022 req_valid changes outside IDLE SHALL be ignored; a requester is not re-accepted before its rsp_valid.
REQ-023 Minimum latency from req_ready to rsp_valid SHALL be 3 cycles for reads and 3 cycles for writes, with a zero-wait slave.

Reset
REQ-024 Asserting s_axi_arstn low SHALL immediately force IDLE, all valid/ready/rsp outputs to 0, rsp_rdata to 0, rsp_err to 0 and the round-robin pointer to requester 1-last (requester 0 wins the first tie); a transaction in flight is abandoned with no rsp_valid.
REQ-025 Reset deassertion SHALL be synchronized internally to s_axi_aclk.

Configuration
REQ-026 With macro DRM_ARB_TIMEOUT_EN defined, a counter SHALL restart at each acceptance; reaching TIMEOUT_CYCLES in any non-IDLE, non-RESP state SHALL drop all AXI valids and readies, then enter RESP with rsp_err=1 and rsp_rdata=32'hDEAD_DEAD.
REQ-027 Without DRM_ARB_TIMEOUT_EN, the block SHALL contain no timeout logic and SHALL wait indefinitely for the slave.

Verification
REQ-028 Read from req 0 at addr 0x0010, slave returns 0x1234_5678/OKAY after 0 waits -> rsp_valid[0] 3 cycles after req_ready[0], rsp_rdata=0x12345678, rsp_err=0.
REQ-029 Both requesters valid continuously, 4 writes each -> grants alternate 0,1,0,1,..., and each rsp_valid matches the requester granted.
REQ-030 Write where slave asserts wready 2 cycles before awready -> wvalid drops first, awvalid holds, and exactly one bvalid handshake follows.
REQ-031 Read where slave returns rresp=2'b10 -> rsp_err=1 and rsp_rdata=slave data.
REQ-032 With DRM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops at cycle 16, rsp_err=1, rsp_rdata=0xDEADDEAD, then the next request is accepted.
REQ-033 Reset asserted during WR_RESP -> outputs 0 immediately, no rsp_valid, and requester 0 wins the first tie after release.

Source files
------------

// File: rtl/drm_axil_req_arbiter_if.sv
// AXI4-Lite channel bundle between the DRM request arbiter (master) and the
// DRM controller register slave.
interface drm_axil_req_arbiter_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/drm_axil_req_arbiter.sv
// Two-requester round-robin arbiter onto one AXI4-Lite master, one transaction in flight.
// Optional watchdog is compiled in with macro DRM_ARB_TIMEOUT_EN.
module drm_axil_req_arbiter #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_arstn,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [2*ADDR_W-1:0]    req_addr,
    input  logic [63:0]            req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    drm_axil_req_arbiter_if.master m_axi
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrResp,
        StRdAddr,
        StRdData,
        StResp
    } state_e;

    // Assert asynchronously, release two clock edges later.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge s_axi_aclk or negedge s_axi_arstn) begin
        if (!s_axi_arstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e            state_q;
    logic              last_q;
    logic              gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [1:0]        rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              grant;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        gnt_onehot;
    logic              aw_done;
    logic              w_done;

    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_q;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
        // Gated by the synchronized reset so nothing is accepted while it is held.
        accept     = rst_n && (state_q == StIdle) && (req_valid != 2'b00);
        req_ready  = 2'b00;
        if (accept) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
        sel_we     = grant ? req_we[1] : req_we[0];
        sel_addr   = grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata  = grant ? req_wdata[63:32] : req_wdata[31:0];
        gnt_onehot = gnt_q ? 2'b10 : 2'b01;
        aw_done    = !awvalid_q || m_axi.awready;
        w_done     = !wvalid_q || m_axi.wready;
    end

`ifdef DRM_ARB_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q;
`else
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge s_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DRM_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        gnt_q   <= grant;
                        last_q  <= grant;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (sel_we) begin
                            state_q   <= StWrAddr;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= StRdAddr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StWrAddr: begin
                    if (m_axi.awready) awvalid_q <= 1'b0;
                    if (m_axi.wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        state_q  <= StWrResp;
                        bready_q <= 1'b1;
                    end
                end
                StWrResp: begin
                    if (m_axi.bvalid) begin
                        bready_q    <= 1'b0;
                        state_q     <= StResp;
                        rsp_valid_q <= gnt_onehot;
                        rsp_err_q   <= m_axi.bresp[1];
                        rsp_rdata_q <= '0;
                    end
                end
                StRdAddr: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (m_axi.rvalid) begin
                        rready_q    <= 1'b0;
                        state_q     <= StResp;
                        rsp_valid_q <= gnt_onehot;
                        rsp_err_q   <= m_axi.rresp[1];
                        rsp_rdata_q <= m_axi.rdata;
                    end
                end
                StResp: begin
                    rsp_valid_q <= 2'b00;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
`ifdef DRM_ARB_TIMEOUT_EN
            // Watchdog overrides whatever the slave handshakes did this cycle.
            if (state_q == StIdle) begin
                tmo_q <= '0;
            end else if (state_q != StResp) begin
                if (tmo_q == TmoLast) begin
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    state_q     <= StResp;
                    rsp_valid_q <= gnt_onehot;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= 32'hDEAD_DEAD;
                end else begin
                    tmo_q <= tmo_q + 16'd1;
                end
            end
`endif
        end
    end

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.rready  = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_drm_axil_req_arbiter.sv
// Directed bench for drm_axil_req_arbiter: vector table plus hand-written corner sequences,
// against a small AXI4-Lite slave model with per-channel wait counts.
module tb_drm_axil_req_arbiter;
    localparam int unsigned ADDR_W = 16;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_pass = 0;
    int n_total = 0;

    int          cfg_aw_wait = 0;
    int          cfg_w_wait = 0;
    int          cfg_ar_wait = 0;
    int          cfg_b_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0;
    logic [1:0]  cfg_bresp = '0;
    logic [15:0] cap_awaddr = '0;
    logic [15:0] cap_araddr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    int          b_count = 0;

    drm_axil_req_arbiter_if #(.ADDR_W(ADDR_W)) axi ();

    drm_axil_req_arbiter #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .s_axi_aclk (clk),
        .s_axi_arstn(arstn),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_axi      (axi)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    // Slave model: acts on negedges; *_fire flags mark handshakes taken at the next posedge.
    initial begin : slave
        logic aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, r_pend;
        int   aw_cnt, w_cnt, ar_cnt, b_cnt;
        {aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, r_pend} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt} = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                {aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, r_pend} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt} = '0;
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
                axi.arready = 1'b0; axi.rvalid = 1'b0;
                continue;
            end
            if (aw_fire) aw_got = 1'b1;
            if (w_fire)  w_got = 1'b1;
            if (b_fire)  axi.bvalid = 1'b0;
            if (r_fire)  axi.rvalid = 1'b0;
            if (ar_fire) r_pend = 1'b1;
            if (aw_got && w_got) begin
                if (b_cnt >= cfg_b_wait) begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = cfg_bresp;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                    b_cnt  = 0;
                end else begin
                    b_cnt++;
                end
            end
            if (r_pend) begin
                axi.rvalid = 1'b1;
                axi.rdata  = cfg_rdata;
                axi.rresp  = cfg_rresp;
                r_pend = 1'b0;
            end
            if (!axi.awvalid) begin axi.awready = 1'b0; aw_cnt = 0; end
            else if (aw_cnt >= cfg_aw_wait) axi.awready = 1'b1;
            else begin axi.awready = 1'b0; aw_cnt++; end
            if (!axi.wvalid) begin axi.wready = 1'b0; w_cnt = 0; end
            else if (w_cnt >= cfg_w_wait) axi.wready = 1'b1;
            else begin axi.wready = 1'b0; w_cnt++; end
            if (!axi.arvalid) begin axi.arready = 1'b0; ar_cnt = 0; end
            else if (ar_cnt >= cfg_ar_wait) axi.arready = 1'b1;
            else begin axi.arready = 1'b0; ar_cnt++; end
            aw_fire = axi.awvalid && axi.awready;
            w_fire  = axi.wvalid && axi.wready;
            ar_fire = axi.arvalid && axi.arready;
            b_fire  = axi.bvalid && axi.bready;
            r_fire  = axi.rvalid && axi.rready;
            if (aw_fire) cap_awaddr = axi.awaddr;
            if (w_fire) begin cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
            if (ar_fire) cap_araddr = axi.araddr;
            if (b_fire) b_count++;
        end
    end

    typedef struct {
        logic        who;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called right after driving at a negedge; returns in the acceptance cycle (or at the bound).
    task automatic wait_ready(output int n);
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk); #1; n++;
        end
    endtask

    // Returns cycles from the current cycle to the rsp_valid cycle (bounded).
    task automatic wait_rsp(input logic drop, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0 && drop) req_valid = 2'b00;
            #1;
            lat++;
        end while (rsp_valid == 2'b00 && lat < 60);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, lat;
        logic [1:0] oh;
        oh = v.who ? 2'b10 : 2'b01;
        cfg_rdata = v.sdata;
        cfg_rresp = v.resp;
        cfg_bresp = v.resp;
        @(negedge clk);
        req_valid = oh;
        // The idle slice carries the inverse so a wrong slice select shows up.
        req_we    = v.who ? {v.we, ~v.we} : {~v.we, v.we};
        req_addr  = v.who ? {v.addr, ~v.addr} : {~v.addr, v.addr};
        req_wdata = v.who ? {v.wdata, ~v.wdata} : {~v.wdata, v.wdata};
        wait_ready(n);
        check($sformatf("vec%0d_accept", idx), req_ready, oh);
        wait_rsp(1'b1, lat);
        check($sformatf("vec%0d_latency", idx), lat, 3);
        check($sformatf("vec%0d_rsp_valid", idx), rsp_valid, oh);
        check($sformatf("vec%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("vec%0d_err", idx), rsp_err, v.exp_err);
        if (v.we) begin
            check($sformatf("vec%0d_awaddr", idx), cap_awaddr, v.addr);
            check($sformatf("vec%0d_wdata", idx), cap_wdata, v.wdata);
            check($sformatf("vec%0d_wstrb", idx), cap_wstrb, 4'hF);
        end else begin
            check($sformatf("vec%0d_araddr", idx), cap_araddr, v.addr);
        end
        @(negedge clk); #1;
        check($sformatf("vec%0d_rsp_pulse", idx), rsp_valid, 2'b00);
    endtask

    initial begin : main
        int n, lat, b_start, n_ar;
        logic [1:0] exp_oh;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0000_0000, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 32'hA5A5_0001, 32'h1111_1111, 2'b00, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h0030, 32'h0000_0000, 32'hCAFE_BABE, 2'b10, 32'hCAFE_BABE, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFC, 32'h0000_0000, 32'h0BAD_F00D, 2'b11, 32'h0BAD_F00D, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 16'h0004, 32'hFFFF_FFFF, 32'h2222_2222, 2'b10, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'h1000, 32'h0000_0001, 32'h3333_3333, 2'b01, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h0008, 32'h0000_0000, 32'h8765_4321, 2'b01, 32'h8765_4321, 1'b0};

        // Reset state, with a request already pending.
        req_valid = 2'b01;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_axi_ctl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready},
              5'b00000);
        @(negedge clk);
        req_valid = 2'b00;
        arstn = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Both requesters held valid: last grant was requester 1, so 0 leads.
        @(negedge clk);
        cfg_bresp = 2'b00;
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr  = {16'h0200, 16'h0100};
        req_wdata = {32'hBBBB_0000, 32'hAAAA_0000};
        for (int k = 0; k < 8; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_ready(n);
            check($sformatf("rr%0d_grant", k), req_ready, exp_oh);
            wait_rsp(1'b0, lat);
            check($sformatf("rr%0d_rsp", k), rsp_valid, exp_oh);
            if (k == 7) req_valid = 2'b00;
        end
        @(negedge clk);

        // W accepted two cycles before AW.
        cfg_aw_wait = 2;
        b_start = b_count;
        @(negedge clk);
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {16'h0000, 16'h0040};
        req_wdata = {32'h0, 32'h5555_AAAA};
        wait_ready(n);
        check("skew_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("skew_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        check("skew_bready_low", axi.bready, 1'b0);
        @(negedge clk); #1;
        check("skew_w_first", {axi.awvalid, axi.wvalid}, 2'b10);
        wait_rsp(1'b0, lat);
        check("skew_latency_from_w_drop", lat, 3);
        check("skew_rsp", rsp_valid, 2'b01);
        check("skew_err", rsp_err, 1'b0);
        repeat (4) @(negedge clk);
        check("skew_one_bresp", b_count - b_start, 1);
        cfg_aw_wait = 0;

`ifdef DRM_ARB_TIMEOUT_EN
        cfg_ar_wait = 100000;
        @(negedge clk);
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {16'h0000, 16'h0080};
        wait_ready(n);
        check("tmo_accept", req_ready, 2'b01);
        n_ar = 0;
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) req_valid = 2'b00;
            #1;
            lat++;
            if (axi.arvalid) n_ar++;
        end while (rsp_valid == 2'b00 && lat < 60);
        check("tmo_arvalid_cycles", n_ar, 16);
        check("tmo_rsp", rsp_valid, 2'b01);
        check("tmo_err", rsp_err, 1'b1);
        check("tmo_rdata", rsp_rdata, 32'hDEAD_DEAD);
        check("tmo_axi_idle", {axi.arvalid, axi.rready}, 2'b00);
        cfg_ar_wait = 0;
        run_vec(vecs[0], 10);
`endif

        // Leave non-zero read data on rsp_rdata, then reset during WR_RESP.
        run_vec(vecs[0], 20);
        cfg_b_wait = 1000;
        @(negedge clk);
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {16'h0000, 16'h0050};
        req_wdata = {32'h0, 32'h0F0F_0F0F};
        wait_ready(n);
        check("wrst_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        check("wrst_in_wr_resp", axi.bready, 1'b1);
        #2;
        arstn = 1'b0;
        #1;
        check("wrst_axi_ctl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready},
              5'b00000);
        check("wrst_rsp_valid", rsp_valid, 2'b00);
        check("wrst_rsp_rdata", rsp_rdata, 32'h0);
        check("wrst_rsp_err", rsp_err, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("wrst_hold%0d_no_rsp", c), rsp_valid, 2'b00);
        end
        cfg_b_wait = 0;
        arstn = 1'b1;
        cfg_rdata = 32'h0000_BEEF;
        cfg_rresp = 2'b00;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {16'h0070, 16'h0060};
        wait_ready(n);
        check("post_rst_tie", req_ready, 2'b01);
        wait_rsp(1'b1, lat);
        check("post_rst_rsp", rsp_valid, 2'b01);
        check("post_rst_rdata", rsp_rdata, 32'h0000_BEEF);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
